// File: rtl/rv32i_types.sv
// Shared RV32I types: cache line and memory burst widths used by the
// cache-to-memory path.
package rv32i_types;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;

  typedef logic [LINE_WIDTH-1:0]  cacheline_t;
  typedef logic [BURST_WIDTH-1:0] burst_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges the cache's single-transfer line port to burst memory.
// A fill collects BEATS beats into line_o. A writeback streams a latched line out beat by beat.
module cacheline_adaptor
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH  = rv32i_types::LINE_WIDTH,
  parameter int BURST_WIDTH = rv32i_types::BURST_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Clears the byte-offset-within-line bits so memory sees a line-aligned address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_WIDTH/8 - 1));

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                state, state_nxt;
  logic [CW-1:0]         count;
  logic [LINE_WIDTH-1:0] wbuf;
  logic                  last;

  assign last = (count == CW'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (write_i)     state_nxt = WRITE;
             else if (read_i) state_nxt = READ;
      READ:  if (resp_i && last) state_nxt = DONE;
      WRITE: if (resp_i && last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_o  = (state == READ);
    write_o = (state == WRITE);
    resp_o  = (state == DONE);
  end

  // wbuf resets to zero, so burst_o is zero out of reset without extra gating.
  assign burst_o = wbuf[int'(count)*BURST_WIDTH +: BURST_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      line_o    <= '0;
      wbuf      <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: if (read_i || write_i) begin
          address_o <= address_i & LINE_MASK;
          count     <= '0;
          if (write_i) wbuf <= line_i;
        end
        READ: if (resp_i) begin
          line_o[int'(count)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
          count <= last ? '0 : count + 1'b1;
        end
        WRITE: if (resp_i) count <= last ? '0 : count + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor. A transaction-level model predicts the
// line, beat order, address and response timing.
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] exp_line;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One cache request. For fills, data supplies the memory beats; for writebacks it is the line.
  // pat_len>0 replays a fixed strobe pattern (LSB first), else strobes are random with gap_pct gaps.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] data, input logic [15:0] pat,
                         input int pat_len, input int gap_pct);
    int beats = 0;
    int cyc   = 0;
    int step  = 0;
    bit s;
    logic [31:0] exp_addr = {addr[31:5], 5'b0};
    @(negedge clk);
    read_i = rd; write_i = wr; address_i = addr;
    line_i = wr ? data : rnd_line();
    resp_i = 1'($urandom_range(1)); burst_i = {$urandom, $urandom};
    @(negedge clk);
    while (beats < 4 && cyc < 200) begin
      chk("read_o_busy",  read_o,  !wr);
      chk("write_o_busy", write_o, wr);
      chk("resp_o_busy",  resp_o,  1'b0);
      chk("address_o",    address_o, exp_addr);
      if (wr) chk("burst_o", burst_o, data[beats*64 +: 64]);
      if (pat_len > 0) s = (step < pat_len) ? pat[step] : 1'b1;
      else             s = ($urandom_range(99) >= gap_pct);
      step++;
      resp_i  = s;
      burst_i = (s && !wr) ? data[beats*64 +: 64] : {$urandom, $urandom};
      if (s) beats++;
      // Request-side churn mid-burst must be ignored.
      address_i = $urandom; line_i = rnd_line();
      read_i = 1'($urandom_range(1)); write_i = 1'($urandom_range(1));
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) chk("burst_timeout", 1'b1, 1'b0);
    resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
    if (!wr) exp_line = data;
    chk("resp_o_done",  resp_o,  1'b1);
    chk("read_o_done",  read_o,  1'b0);
    chk("write_o_done", write_o, 1'b0);
    chk("line_o_done",  line_o,  exp_line);
    @(negedge clk);
    chk("resp_o_once",  resp_o,  1'b0);
    chk("read_o_idle",  read_o,  1'b0);
    chk("write_o_idle", write_o, 1'b0);
    chk("line_o_hold",  line_o,  exp_line);
  endtask

  initial begin
    logic [255:0] d;
    logic [31:0]  a;
    int kind;
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    line_i = '0; address_i = '0; burst_i = '0;
    exp_line = '0;
    repeat (2) @(negedge clk);
    chk("rst_line_o", line_o, '0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_strobes", {read_o, write_o, resp_o}, 3'b000);
    rst = 1'b0;

    // Directed fill: beat 0 lands in the lowest slice, address aligned down.
    d = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    run_txn(1'b1, 1'b0, 32'h0000_1234, d, 16'h0, 0, 0);
    chk("fill_address_o", address_o, 32'h0000_1220);

    // Directed writeback, then gapped fill with strobes 1,0,0,1,1,0,1.
    run_txn(1'b0, 1'b1, 32'h0000_4000, rnd_line(), 16'h0, 0, 0);
    run_txn(1'b1, 1'b0, 32'h0000_8abc, rnd_line(), 16'h0059, 7, 0);
    // Both requests high: writeback goes first.
    run_txn(1'b1, 1'b1, 32'hdead_beef, rnd_line(), 16'h0, 0, 30);

    // Stray strobes in IDLE must neither respond nor advance the beat counter.
    a = address_o;
    repeat (5) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_resp_o", resp_o, 1'b0);
      chk("idle_reqs", {read_o, write_o}, 2'b00);
      chk("idle_line_o", line_o, exp_line);
      chk("idle_address_o", address_o, a);
    end
    resp_i = 1'b0;
    run_txn(1'b1, 1'b0, 32'h1234_5678, rnd_line(), 16'h0, 0, 0);

    // Reset mid-fill after two beats abandons the burst.
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_0100;
    @(negedge clk);
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    burst_i = {$urandom, $urandom};
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_line_o", line_o, '0);
    chk("midrst_burst_o", burst_o, '0);
    chk("midrst_address_o", address_o, '0);
    chk("midrst_strobes", {read_o, write_o, resp_o}, 3'b000);
    exp_line = '0;
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b1, 1'b0, 32'h0000_0140, rnd_line(), 16'h0, 0, 0);

    // Random mix of fills, writebacks and simultaneous requests.
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(2);
      run_txn(kind != 1, kind != 0, $urandom, rnd_line(), 16'h0, 0, $urandom_range(60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
